// File: rtl/lfsr_decrypt_seq.sv
// lfsr_decrypt_seq: recovers LFSR seed/taps from a zero preamble, then decrypts, strips and pads a message in memory
module lfsr_decrypt_seq #(
  parameter int SRC_BASE = 64,
  parameter int DST_BASE = 0,
  parameter int LEN = 64,
  parameter int SEARCH_LEN = 9
) (
  input  logic       clk,
  input  logic       init,
  input  logic       req,
  output logic       ack,
  output logic       err,
  output logic [3:0] pat_idx,
  output logic [6:0] lead_cnt,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
);
  typedef enum logic [2:0] {IDLE, SEED, SEARCH, DECRYPT, PAD, DONE} state_t;
  localparam logic [6:0] TAPS [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
  state_t state;
  logic prev_req, ph, ok, lead;
  logic [3:0] p, j;
  logic [6:0] s, s0, i, w;
  logic [7:0] addr_q;
  logic [6:0] tap, nxt, pt;
  logic bad, hit, skip, wr_phase, fin;
  assign tap = TAPS[p];
  assign nxt = {s[5:0], ^(s & tap)};
  assign bad = mem_rd_data[7] != ^mem_rd_data[6:0];
  assign hit = bad || mem_rd_data[6:0] == nxt;
  assign pt = mem_rd_data[6:0] ^ s;
  assign skip = lead && !bad && pt == 7'd0;
  assign fin = !skip && w == 7'(LEN - 1);
  assign wr_phase = (state == DECRYPT && ph) || state == PAD;
  assign mem_addr = wr_phase ? 8'(DST_BASE) + {1'b0, w} : addr_q;
  assign mem_wr_en = state == PAD || (state == DECRYPT && ph && !skip);
  assign mem_wr_data = (state == DECRYPT && ph) ? {bad, pt} : 8'h00;
  always_ff @(posedge clk) begin
    prev_req <= req;
    if (init) begin
      state <= IDLE;
      ack <= 1'b0;
      err <= 1'b0;
      pat_idx <= 4'd0;
      lead_cnt <= 7'd0;
      addr_q <= 8'd0;
      ph <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!req && prev_req) begin
          state <= SEED;
          addr_q <= 8'(SRC_BASE);
          ph <= 1'b0;
        end
        SEED: begin
          ph <= !ph;
          if (ph) begin
            if (bad || mem_rd_data[6:0] == 7'd0) begin
              state <= DONE;
              ack <= 1'b1;
              err <= 1'b1;
            end else begin
              s0 <= mem_rd_data[6:0];
              s <= mem_rd_data[6:0];
              p <= 4'd0;
              j <= 4'd0;
              ok <= 1'b1;
              addr_q <= 8'(SRC_BASE + 1);
              state <= SEARCH;
            end
          end
        end
        SEARCH: begin
          addr_q <= addr_q + 8'd1;
          j <= j + 4'd1;
          if (j != 4'd0) begin
            s <= nxt;
            ok <= ok && hit;
          end
          if (j == 4'(SEARCH_LEN)) begin
            s <= s0;
            j <= 4'd0;
            ok <= 1'b1;
            addr_q <= 8'(SRC_BASE + 1);
            if (ok && hit) begin
              state <= DECRYPT;
              pat_idx <= p;
              addr_q <= 8'(SRC_BASE);
              ph <= 1'b0;
              i <= 7'd0;
              w <= 7'd0;
              lead <= 1'b1;
              lead_cnt <= 7'd0;
            end else if (p == 4'd8) begin
              state <= DONE;
              ack <= 1'b1;
              err <= 1'b1;
            end else p <= p + 4'd1;
          end
        end
        DECRYPT: begin
          ph <= !ph;
          if (ph) begin
            s <= nxt;
            i <= i + 7'd1;
            addr_q <= addr_q + 8'd1;
            if (skip) lead_cnt <= lead_cnt + 7'd1;
            else begin
              lead <= 1'b0;
              w <= w + 7'd1;
            end
            if (i == 7'(LEN - 1)) begin
              state <= fin ? DONE : PAD;
              ack <= fin;
            end
          end
        end
        PAD: begin
          w <= w + 7'd1;
          if (w == 7'(LEN - 1)) begin
            state <= DONE;
            ack <= 1'b1;
          end
        end
        DONE: if (req && !prev_req) begin
          state <= IDLE;
          ack <= 1'b0;
          err <= 1'b0;
          pat_idx <= 4'd0;
          lead_cnt <= 7'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/lfsr_decrypt_seq.md
# lfsr_decrypt_seq

Hardware sequencer that decrypts an LFSR-encrypted, parity-tagged message from data memory and strips its leading padding. It is a bus master on the data memory port next to the processor core. It recovers the LFSR state and tap pattern from the known all-zero preamble, decrypts 64 bytes and drops leading zero (space) bytes. It then writes the compacted plaintext, padded with zeros, back to memory and flags parity-corrupted characters. Control uses the same init/req/ack handshake as top_level.

## Interface
- SRC_BASE, 64: first encrypted byte address.
- DST_BASE, 0: first plaintext output address.
- LEN, 64: bytes processed and bytes written.
- SEARCH_LEN, 9: preamble transitions checked per candidate pattern.
- clk  in  1  system clock; all logic on the rising edge.
- init  in  1  synchronous active-high reset.
- req  in  1  high = hold; a 1→0 transition starts a run.
- ack  out  1  run complete; held until init or req rises.
- err  out  1  no valid seed or no tap pattern matched; valid with ack.
- pat_idx  out  4  index 0–8 of the matched tap pattern.
- lead_cnt  out  7  count of leading bytes stripped, 0–64.
- mem_addr  out  8  memory address.
- mem_rd_data  in  8  read data, 1-cycle synchronous latency.
- mem_wr_en  out  1  write strobe.
- mem_wr_data  out  8  write data.

## Operation
- Tap table, fixed ROM: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
- LFSR step: next = {s[5:0], ^(s & tap)}, 7 bits.
- Parity check: a byte is good when b[7] == ^b[6:0].
- States run IDLE → SEED → SEARCH → DECRYPT → PAD → DONE.
- IDLE: wait for req falling, i.e. req low with previous req high.
- SEED: read SRC_BASE. If parity is bad or b[6:0] == 0, go to DONE with err=1. Otherwise s0 = b[6:0].
- SEARCH, for p = 0..8:
  - Predict s1..s9 from s0 using tap[p].
  - Compare each prediction with mem[SRC_BASE+k][6:0], k = 1..9.
  - A byte with bad parity is a wildcard and is not compared.
  - The first p with all compared bytes matching wins; set pat_idx = p.
  - If no p matches, go to DONE with err=1 and pat_idx=0. Nothing is written in either error case.
- DECRYPT, for i = 0..LEN-1:
  - Plaintext pt = crypt[6:0] ^ s_i.
  - While the leading run is active and pt == 0 with good parity, skip the byte and increment lead_cnt.
  - Otherwise the leading run ends and the sequencer writes {parity_bad, pt} to DST_BASE+w, then increments w.
  - A bad-parity byte always ends the leading run and is always written with bit 7 set.
  - Interior zero bytes are written.
- PAD: write 0x00 to DST_BASE+w .. DST_BASE+LEN-1.
- DONE: ack=1. Outputs stay stable until init, or until req rises, which returns the block to IDLE and clears ack, err, pat_idx and lead_cnt.

## Timing
- Reset values: ack=0, err=0, pat_idx=0, lead_cnt=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, state IDLE.
- SEED takes 2 cycles: address cycle plus capture cycle.
- SEARCH takes 10 cycles per candidate tried: 9 pipelined reads plus 1 drain/compare cycle. Candidates run in order; there is no early abort within a candidate.
- DECRYPT takes 2 cycles per byte: read-address cycle, then data-capture cycle in which the write is issued if the byte is emitted. The memory is never read and written in the same cycle.
- PAD takes 1 cycle per padded address, LEN − w cycles in total.
- ack rises the cycle after the last write, or the cycle after the failing SEED/SEARCH decision.
- Total latency from req falling to ack = 1 + 2 + 10·(pat_idx+1) + 2·LEN + (LEN−w).
- init is honoured in any state, including mid-DECRYPT or PAD: the block returns to IDLE next cycle with mem_wr_en=0 and no further writes. Memory contents already written are left as they are.
- req rising during a run is ignored; it only acts in DONE.
- req held low after DONE does not restart; a new run needs another req 1→0.

## Test plan
- Pattern 0x60, seed 0x01, pre_length 10, message "Hi" (0x28, 0x49 after subtracting 0x20) → pat_idx=0, lead_cnt=10, DM[0..1]=0x28, 0x49, DM[2..63]=0x00, err=0, ack after 1+2+10+128+62 cycles.
- Pattern 0x7B (index 8), random nonzero seed, 41-char message with 1 leading space and pre_length 15 → pat_idx=8, lead_cnt=16, output matches the bench model byte-for-byte, latency includes 90 search cycles.
- Single bit flip in crypt byte 30 (message interior) → output byte at its position has bit7=1; all others are clean.
- Bit flip in preamble byte 3 → treated as wildcard; the correct pattern is still found, and bit 7 is set on the written byte because parity ends the leading run, so lead_cnt=3.
- DM[64]=0x00 → err=1, ack high, no writes to DM[0..63]. Separately, all 64 plaintext bytes zero → lead_cnt=64 and 64 pad writes of 0x00.
- Assert init during DECRYPT byte 20 → next cycle state is IDLE, ack=0, no writes after; then req 1→0 completes a clean run.
